// File: rtl/rram_mem_pkg.sv
// ---------------------------------------------------------------------------
// rram_mem_pkg : shared types and size-code helpers for the RAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rram_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;
  localparam logic [2:0] SZ_Q = 3'd4;

  function automatic logic [15:0] size2mask(input logic [2:0] size);
    logic [15:0] m;
    case (size)
      SZ_B:    m = 16'h0001;
      SZ_H:    m = 16'h0003;
      SZ_W:    m = 16'h000F;
      SZ_D:    m = 16'h00FF;
      SZ_Q:    m = 16'hFFFF;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Illegal size codes are reported as misaligned so both share one error path.
  function automatic logic misaligned(input logic [3:0] addr_lo, input logic [2:0] size);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = |addr_lo[1:0];
      SZ_D:    bad = |addr_lo[2:0];
      SZ_Q:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rram_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter, pointer moves away from each winner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic rr_ptr;

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = rr_ptr;
      default: grant_idx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_ptr <= 1'b0;
    else if (advance && grant_valid)
      rr_ptr <= ~grant_idx;
  end

endmodule

`default_nettype wire

// File: rtl/rram_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rram_mem_arbiter : round-robin burst sequencer in front of the byte-lane RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rram_mem_arbiter
  import rram_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cmd_valid,
  output logic [1:0]            cmd_ready,
  input  logic [1:0]            cmd_write,
  input  logic [2*ADDR_W-1:0]   cmd_addr,
  input  logic [5:0]            cmd_size,
  input  logic [2*LEN_W-1:0]    cmd_len,
  input  logic [1:0]            wvalid,
  output logic [1:0]            wready,
  input  logic [255:0]          wdata,
  output logic [1:0]            rvalid,
  output logic [127:0]          rdata,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [15:0]           ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_W-1:0]     ram_addra,
  output logic [127:0]          ram_dina,
  input  logic [127:0]          ram_douta
);

  state_t              state;
  logic                gnt;
  logic                write_q;
  logic [2:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    cnt;
  logic [15:0]         mask_q;
  logic                err_q;
  logic [1:0]          rvalid_q;

  logic                grant_valid;
  logic                grant_idx;
  logic                advance;
  logic [ADDR_W-1:0]   sel_addr;
  logic [2:0]          sel_size;
  logic [LEN_W-1:0]    sel_len;
  logic                sel_write;
  logic                sel_bad;
  logic                beat;
  logic [ADDR_W-1:0]   step;
  logic [1:0]          owner;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (cmd_valid),
    .advance     (advance),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign advance   = rst_n && (state == IDLE) && grant_valid;
  assign sel_addr  = grant_idx ? cmd_addr[2*ADDR_W-1:ADDR_W] : cmd_addr[ADDR_W-1:0];
  assign sel_size  = grant_idx ? cmd_size[5:3] : cmd_size[2:0];
  assign sel_len   = grant_idx ? cmd_len[2*LEN_W-1:LEN_W] : cmd_len[LEN_W-1:0];
  assign sel_write = grant_idx ? cmd_write[1] : cmd_write[0];
  assign sel_bad   = misaligned(sel_addr[3:0], sel_size);

  assign owner = {gnt, ~gnt};
  assign step  = ADDR_W'(1) << size_q;

  // A write beat only exists when the owning requester presents data.
  assign beat = (state == BURST) && (!write_q || (gnt ? wvalid[1] : wvalid[0]));

  assign cmd_ready = advance ? {grant_idx, ~grant_idx} : 2'b00;
  assign wready    = ((state == BURST) && write_q) ? owner : 2'b00;
  assign ram_ena   = beat ? mask_q : 16'h0000;
  assign ram_wea   = beat && write_q;
  assign ram_addra = beat ? addr_q : '0;
  assign ram_dina  = (beat && write_q) ? (gnt ? wdata[255:128] : wdata[127:0]) : 128'd0;
  assign rvalid    = rvalid_q;
  assign rdata     = (|rvalid_q) ? ram_douta : 128'd0;
  assign done      = (state == RESP) ? owner : 2'b00;
  assign err       = (state == RESP && err_q) ? owner : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
      addr_q   <= '0;
      cnt      <= '0;
      mask_q   <= 16'h0000;
      err_q    <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= (beat && !write_q) ? owner : 2'b00;
      case (state)
        IDLE: begin
          if (advance) begin
            gnt     <= grant_idx;
            write_q <= sel_write;
            size_q  <= sel_size;
            addr_q  <= sel_addr;
            cnt     <= sel_len;
            mask_q  <= size2mask(sel_size);
            err_q   <= sel_bad;
            state   <= sel_bad ? RESP : BURST;
          end
        end
        BURST: begin
          if (beat) begin
            addr_q <= addr_q + step;
            cnt    <= cnt - LEN_W'(1);
            if (cnt == '0)
              state <= write_q ? RESP : DRAIN;
          end
        end
        DRAIN: state <= RESP;
        RESP: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rram_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rram_mem_arbiter : directed vectors for the RAM arbiter with a byte-lane RAM model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rram_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   cmd_valid, cmd_ready, cmd_write, wvalid, wready, rvalid, done, err;
  logic [15:0]  cmd_addr;
  logic [5:0]   cmd_size;
  logic [7:0]   cmd_len;
  logic [255:0] wdata;
  logic [127:0] rdata, ram_dina, ram_douta;
  logic [15:0]  ram_ena;
  logic         ram_wea;
  logic [7:0]   ram_addra;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rram_mem_arbiter #(.ADDR_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rdata(rdata), .done(done), .err(err),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  // Byte-lane RAM: lanes enabled by ram_ena, registered read, zero in disabled lanes.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++) begin
      if (ram_wea && ram_ena[k]) mem[8'(ram_addra + k)] <= ram_dina[8*k +: 8];
      ram_douta[8*k +: 8] <= ram_ena[k] ? mem[8'(ram_addra + k)] : 8'h00;
    end
  end

  typedef struct {
    int           r;
    bit           wr;
    logic [7:0]   addr;
    logic [2:0]   size;
    logic [3:0]   len;
    logic [127:0] wd;
    int           wdelay;
    bit           exp_err;
    int           exp_beats;
    logic [15:0]  exp_ena;
    logic [7:0]   exp_last;
    int           exp_done;
    logic [127:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {cmd_ready, wready, rvalid, done, err, ram_ena, ram_wea, ram_addra} | rdata | ram_dina;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int taken = 0, nbeats = 0, nwea = 0, nrv = 0, nready = 0, other = 0;
    int first_rv = 0, last_rv = 0, done_cyc = -1;
    bit got_ready = 0, done_seen = 0, err_s = 0;
    logic [15:0]  ena0 = 16'h0;
    logic [7:0]   lastaddr = 8'h0;
    logic [127:0] rd0 = 128'h0;
    int o = 1 - v.r;
    @(posedge clk); #1;
    cmd_valid[v.r]             = 1'b1;
    cmd_write[v.r]             = v.wr;
    cmd_addr[v.r*8 +: 8]       = v.addr;
    cmd_size[v.r*3 +: 3]       = v.size;
    cmd_len[v.r*4 +: 4]        = v.len;
    wdata[v.r*128 +: 128]      = v.wd;
    wvalid                     = 2'b00;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (got_ready) cmd_valid[v.r] = 1'b0;
        wvalid[v.r] = v.wr && (cyc >= 1 + v.wdelay) && (taken < v.exp_beats);
      end
      @(negedge clk);
      if (cmd_ready[v.r]) begin nready++; got_ready = 1; end
      if (cmd_ready[o] | wready[o] | rvalid[o] | done[o] | err[o]) other++;
      if (wvalid[v.r] && wready[v.r]) taken++;
      if (ram_wea) nwea++;
      if (ram_ena != 16'h0) begin
        if (nbeats == 0) ena0 = ram_ena;
        lastaddr = ram_addra;
        nbeats++;
      end
      if (rvalid[v.r]) begin
        if (nrv == 0) begin rd0 = rdata; first_rv = cyc; end
        last_rv = cyc;
        nrv++;
      end
      if (done[v.r]) begin done_seen = 1; done_cyc = cyc; err_s = err[v.r]; end
    end
    wvalid = 2'b00;
    cmd_valid = 2'b00;
    chk($sformatf("v%0d_done_seen", idx), done_seen, 1);
    chk($sformatf("v%0d_ready_pulses", idx), nready, 1);
    chk($sformatf("v%0d_other_req_quiet", idx), other, 0);
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    chk($sformatf("v%0d_err", idx), err_s, v.exp_err);
    chk($sformatf("v%0d_ram_beats", idx), nbeats, v.exp_beats);
    chk($sformatf("v%0d_wea_pulses", idx), nwea, v.wr ? v.exp_beats : 0);
    if (v.exp_beats > 0) begin
      chk($sformatf("v%0d_ena", idx), ena0, v.exp_ena);
      chk($sformatf("v%0d_last_addr", idx), lastaddr, v.exp_last);
    end
    if (!v.wr) chk($sformatf("v%0d_rvalid_beats", idx), nrv, v.exp_beats);
    if (!v.wr && v.exp_beats > 0) begin
      chk($sformatf("v%0d_rvalid_b2b", idx), last_rv - first_rv + 1, v.exp_beats);
      chk($sformatf("v%0d_rdata0", idx), rd0, v.exp_rd);
    end
  endtask

  initial begin
    int g_seq [4];
    int rv_seq [4];
    int ng, nrv, ndone, overlap;
    int exp_alt [4] = '{0, 1, 0, 1};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst_n = 1'b0; cmd_valid = '0; cmd_write = '0; cmd_addr = '0; cmd_size = '0;
    cmd_len = '0; wvalid = '0; wdata = '0;

    //         r wr addr   sz    len   wdata                       dly err beats ena       last   done rdata
    vecs[0]  = '{0, 0, 8'h10, 3'd4, 4'd1, 128'h0,                      0, 0, 2, 16'hFFFF, 8'h20, 4,
                 128'h1f1e1d1c1b1a19181716151413121110};
    vecs[1]  = '{1, 1, 8'h06, 3'd1, 4'd0, 128'hBEEF,                   3, 0, 1, 16'h0003, 8'h06, 5, 128'h0};
    vecs[2]  = '{0, 0, 8'h06, 3'd1, 4'd0, 128'h0,                      0, 0, 1, 16'h0003, 8'h06, 3, 128'hBEEF};
    vecs[3]  = '{0, 0, 8'h03, 3'd2, 4'd0, 128'h0,                      0, 1, 0, 16'h0000, 8'h00, 1, 128'h0};
    vecs[4]  = '{0, 0, 8'h00, 3'd6, 4'd0, 128'h0,                      0, 1, 0, 16'h0000, 8'h00, 1, 128'h0};
    vecs[5]  = '{1, 0, 8'hFE, 3'd0, 4'd3, 128'h0,                      0, 0, 4, 16'h0001, 8'h01, 6, 128'hFE};
    vecs[6]  = '{1, 1, 8'h20, 3'd3, 4'd2, 128'h1122334455667788,       0, 0, 3, 16'h00FF, 8'h30, 4, 128'h0};
    vecs[7]  = '{0, 0, 8'h28, 3'd3, 4'd0, 128'h0,                      0, 0, 1, 16'h00FF, 8'h28, 3,
                 128'h1122334455667788};
    vecs[8]  = '{1, 1, 8'h42, 3'd2, 4'd1, 128'h12345678,               0, 1, 0, 16'h0000, 8'h00, 1, 128'h0};
    vecs[9]  = '{1, 0, 8'h50, 3'd2, 4'd0, 128'h0,                      0, 0, 1, 16'h000F, 8'h50, 3, 128'hCAFEF00D};
    vecs[10] = '{0, 0, 8'h58, 3'd2, 4'd0, 128'h0,                      0, 0, 1, 16'h000F, 8'h58, 3, 128'h5b5a5958};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", all_outs(), 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simultaneous requests straight out of reset must alternate 0,1,0,1.
    cmd_valid = 2'b11; cmd_write = 2'b00;
    cmd_addr = {8'h01, 8'h00}; cmd_size = 6'd0; cmd_len = 8'd0;
    ng = 0; nrv = 0; ndone = 0; overlap = 0;
    for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (cmd_ready == 2'b11 || rvalid == 2'b11 || done == 2'b11) overlap++;
      if (|cmd_ready && ng < 4) begin g_seq[ng] = cmd_ready[1] ? 1 : 0; ng++; end
      if (|rvalid && nrv < 4) begin
        rv_seq[nrv] = rvalid[1] ? 1 : 0;
        chk($sformatf("alt_rdata%0d", nrv), rdata, 128'(exp_alt[nrv]));
        nrv++;
      end
      if (|done) ndone++;
    end
    @(posedge clk); #1;
    cmd_valid = 2'b00;
    chk("alt_grants", ng, 4);
    chk("alt_rvalids", nrv, 4);
    chk("alt_overlap", overlap, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("alt_grant%0d", k), g_seq[k], exp_alt[k]);
      chk($sformatf("alt_rvalid_owner%0d", k), rv_seq[k], exp_alt[k]);
    end

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset arriving during the second beat of a 4-beat write.
    @(posedge clk); #1;
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[7:0] = 8'h50;
    cmd_size[2:0] = 3'd2; cmd_len[3:0] = 4'd3; wdata[127:0] = 128'hCAFEF00D;
    @(negedge clk);
    chk("rst_burst_ready", cmd_ready, 2'b01);
    @(posedge clk); #1;
    cmd_valid = 2'b00; wvalid[0] = 1'b1;
    @(negedge clk);
    chk("rst_burst_beat0", {ram_wea, ram_addra}, {1'b1, 8'h50});
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rst_hold_zero%0d", k), all_outs(), 128'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; wvalid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_no_wea%0d", k), ram_wea, 1'b0);
      @(posedge clk); #1;
    end

    run_vec(vecs[9], 9);
    run_vec(vecs[10], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rram_mem_arbiter.md
Name: rram_mem_arbiter

Overview:
- Two-port arbiter and burst sequencer in front of the 128-bit unaligned byte-lane RAM model (16-bit size-mask enable, single write strobe, 1-cycle registered read).
- Shares the RAM between requester 0 (DMA read channel) and requester 1 (DMA write channel) with round-robin grants.
- Expands each burst command into per-beat RAM accesses and translates the size code into the RAM's enable mask.
- Rejects misaligned commands with an error completion and no RAM access.

Parameters:
- ADDR_W, 8, RAM byte-address width; must equal the RAM's OUTER_ADDR_SIZE.
- LEN_W, 4, burst-length field width; beats = len+1 (1..16).

Ports:
- clk  in  1  single clock for the block and the RAM.
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid  in  2  per-requester command valid; bit i is requester i.
- cmd_ready  out  2  command accepted on valid&ready.
- cmd_write  in  2  1 = write burst, 0 = read burst.
- cmd_addr  in  2*ADDR_W  start byte address; slice i is [i*ADDR_W +: ADDR_W].
- cmd_size  in  2*3  size code per requester: 0=1B, 1=2B, 2=4B, 3=8B, 4=16B; 5-7 are illegal.
- cmd_len  in  2*LEN_W  beats minus one.
- wvalid  in  2  write beat valid.
- wready  out  2  write beat taken.
- wdata  in  2*128  write beat data, right-justified (LSBs).
- rvalid  out  2  read beat valid; there is no backpressure, so the requester must sink it.
- rdata  out  128  read beat data, zero-extended by the RAM; shared by both requesters and qualified by rvalid.
- done  out  2  1-cycle completion pulse per burst.
- err  out  2  qualifies done: misaligned or illegal size.
- ram_ena  out  16  size mask: 0x0001, 0x0003, 0x000F, 0x00FF or 0xFFFF.
- ram_wea  out  1  RAM write strobe.
- ram_addra  out  ADDR_W  RAM byte address.
- ram_dina  out  128  RAM write data.
- ram_douta  in  128  RAM read data, valid the cycle after the read issue.

Behaviour:
- Reset values (rst_n=0 at posedge): all outputs 0 (cmd_ready, wready, rvalid, rdata, done, err, ram_*), FSM=IDLE, rr_ptr=0.
- FSM states: IDLE, BURST, DRAIN, RESP.
- IDLE arbitration:
  - If any cmd_valid is set, grant one requester; cmd_ready[g]=1 for exactly one cycle.
  - On a tie, the winner is the requester indicated by rr_ptr; rr_ptr <= ~g after each grant.
  - A lone requester always wins.
- Command capture:
  - Latch addr, size, len and write.
  - If size>4, or addr & ((1<<size)-1) != 0, go to RESP with err=1.
  - Otherwise go to BURST with beat counter = len.
- Enable mask: ram_ena = (1 << (1<<size)) - 1, held constant for the whole burst.
- BURST, read:
  - One beat issued per cycle: ram_wea=0, ram_addra=current address.
  - Address advances by 1<<size per beat and wraps modulo 2^ADDR_W.
  - After the last beat, go to DRAIN.
- BURST, write:
  - wready[g]=1 while in BURST; a beat is issued only in a cycle with wvalid[g]&wready[g].
  - On that beat: ram_wea=1 and ram_dina=wdata[g].
  - No beat is issued while wvalid is low; ram_wea=0 in those cycles.
  - After the last beat, go to RESP.
- Read data return:
  - rvalid[g] is asserted the cycle after each read issue, with rdata=ram_douta.
  - Read latency is exactly 1 cycle, and beats are back-to-back for a burst.
- DRAIN: delivers the final read beat, then goes to RESP.
- RESP: done[g]=1 (plus err[g] on error) for one cycle, then IDLE. The next grant can occur the cycle after RESP.
- Outside active beats: ram_ena=0 and ram_wea=0; the RAM then performs a harmless default-mask read.
- Non-granted requester: cmd_ready, wready, rvalid, done and err all held 0 for the duration of the other's burst.
- Arbitration boundaries:
  - A requester dropping cmd_valid while not granted is legal.
  - A granted command is never aborted.
- Reset mid-burst: return to IDLE immediately. No further RAM writes are issued, and outstanding read data is discarded (rvalid=0).
- Throughput, single-beat read: grant, issue, drain and resp take 4 cycles from cmd_valid to done.

Decomposition:
- Shared package rram_mem_pkg holds:
  - the state enum;
  - the size-code constants (SZ_B, SZ_H, SZ_W, SZ_D, SZ_Q);
  - function size2mask(size) returning logic[15:0];
  - function misaligned(addr, size).
- One natural sub-module, rr_arb2: 2-way round-robin arbiter with priority-pointer update on grant.

Test Plan:
- Req0 read, addr 0x10, size 4, len 1 -> ram_ena=0xFFFF at addra 0x10 then 0x20; rvalid[0] two consecutive cycles; done[0] with err=0.
- Req1 write, addr 0x06, size 1, len 0, wdata 0xBEEF with wvalid delayed 3 cycles -> ram_wea is exactly one pulse, ena=0x0003, addra=0x06; then a read-back of that location returns 0x0000...BEEF.
- Both cmd_valid asserted after reset, and again repeatedly -> grants alternate 0,1,0,1; no overlap on ram_* between bursts.
- Req0 size 2 at addr 0x03 -> no RAM access (ram_wea=0, ram_ena=0); done[0]=err[0]=1. Also size 6 -> same error response.
- Byte read burst, addr 0xFE, size 0, len 3 -> addresses 0xFE, 0xFF, 0x00, 0x01 (wrap); ena=0x0001.
- rst_n low in the second beat of a 4-beat write -> no ram_wea after reset; FSM in IDLE; all outputs 0; a new command is accepted normally afterwards.
